// File: rtl/mem_pkg.sv
// Shared types for the memory request path: default widths, opcode, request record.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_issuer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Status flags come from registered
// pointers only, so a pop never frees space in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // full when the wrap bits differ but the index bits match
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // pointer update; reset discards any buffered entries
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_req_issuer.sv
// Request stage in front of memory_controller: buffers requests, issues them in
// program order under a credit cap, and registers completions back upstream.
module mem_req_issuer
  import mem_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mc_wr_en,
  output logic [ADDR_W-1:0] mc_wr_address,
  output logic [DATA_W-1:0] mc_wr_data,
  output logic              mc_rd_en,
  output logic [ADDR_W-1:0] mc_rd_address,
  input  logic              mc_wr_ret_ack,
  input  logic [ADDR_W-1:0] mc_wr_ret_address,
  input  logic              mc_rd_ret_ack,
  input  logic [ADDR_W-1:0] mc_rd_ret_address,
  input  logic [DATA_W-1:0] mc_rd_ret_data,
  output logic              wr_rsp_valid,
  output logic [ADDR_W-1:0] wr_rsp_address,
  output logic              rd_rsp_valid,
  output logic [ADDR_W-1:0] rd_rsp_address,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic [3:0]        outstanding,
  output logic              err_underflow
);

  localparam int         REQ_W   = $bits(mem_req_t);
  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  // elaboration-time guards on the parameter set
  generate
    if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_bad_width
      $error("mem_req_issuer: ADDR_W/DATA_W must match mem_pkg request widths");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
      $error("mem_req_issuer: MAX_OUTSTANDING must be 1..15");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_req_issuer: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  mem_req_t         push_req;
  mem_req_t         head_req;
  logic [REQ_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] unused_fifo_count;  // level not needed here; flags suffice

  logic [4:0]       out_plus;
  logic [4:0]       out_dec;
  logic [4:0]       out_diff;
  logic             underflow_now;

  assign push_req = '{op: (req_write ? OP_WRITE : OP_READ),
                      address: req_address,
                      wdata: req_wdata};

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .din   (push_req),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign head_req = mem_req_t'(head_bits);

  // credit check uses the count as it stood at the start of the cycle
  assign issue = !fifo_empty && (outstanding < MAX_OUT);

  // one registered strobe per issue; address/data hold between issues
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_wr_en      <= 1'b0;
      mc_rd_en      <= 1'b0;
      mc_wr_address <= '0;
      mc_wr_data    <= '0;
      mc_rd_address <= '0;
    end else begin
      mc_wr_en <= issue && (head_req.op == OP_WRITE);
      mc_rd_en <= issue && (head_req.op == OP_READ);
      if (issue && head_req.op == OP_WRITE) begin
        mc_wr_address <= head_req.address;
        mc_wr_data    <= head_req.wdata;
      end
      if (issue && head_req.op == OP_READ) begin
        mc_rd_address <= head_req.address;
      end
    end
  end

  // net credit change: +1 per issue, -1 per ack; below zero clamps and flags
  assign out_plus      = {1'b0, outstanding} + {4'd0, issue};
  assign out_dec       = {4'd0, mc_wr_ret_ack} + {4'd0, mc_rd_ret_ack};
  assign out_diff      = out_plus - out_dec;
  assign underflow_now = (out_plus < out_dec);

  // in-flight counter and sticky underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= underflow_now ? 4'd0 : out_diff[3:0];
      if (underflow_now) err_underflow <= 1'b1;
    end
  end

  // completions pass straight back, one register stage, no backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_rsp_valid   <= 1'b0;
      wr_rsp_address <= '0;
      rd_rsp_valid   <= 1'b0;
      rd_rsp_address <= '0;
      rd_rsp_data    <= '0;
    end else begin
      wr_rsp_valid   <= mc_wr_ret_ack;
      wr_rsp_address <= mc_wr_ret_address;
      rd_rsp_valid   <= mc_rd_ret_ack;
      rd_rsp_address <= mc_rd_ret_address;
      rd_rsp_data    <= mc_rd_ret_data;
    end
  end

endmodule
